// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: bundles the EX-side request/result signals and the divider
// handshake of the multiply/divide sequencer.
//   slave  : seen by mdu_ctrl (EX and divider inputs in, results and divider
//            controls out)
//   master : seen by the environment (EX stage plus divider)
interface mdu_ctrl_if;
  logic        valid_i;
  logic [3:0]  op_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        flush_i;
  logic        div_start_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        div_annul_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stallreq_o;
  logic        busy_o;
  logic        done_o;
  logic [63:0] hilo_o;

  modport slave (
    input  valid_i, op_i, reg1_i, reg2_i, hi_i, lo_i, flush_i,
           div_result_i, div_ready_i,
    output div_start_o, div_signed_o, div_opdata1_o, div_opdata2_o,
           div_annul_o, stallreq_o, busy_o, done_o, hilo_o
  );

  modport master (
    output valid_i, op_i, reg1_i, reg2_i, hi_i, lo_i, flush_i,
           div_result_i, div_ready_i,
    input  div_start_o, div_signed_o, div_opdata1_o, div_opdata2_o,
           div_annul_o, stallreq_o, busy_o, done_o, hilo_o
  );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer beside the EX stage.
// Runs MULT/MULTU/MADD/MADDU/MSUB/MSUBU through a registered two-stage
// multiply-accumulate, hands DIV/DIVU to the external iterative divider, and
// holds the EX stall until a one-cycle done_o presents the {HI,LO} result.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-low reset
//   bus  - mdu_ctrl_if.slave: EX request (valid/op/operands/HI/LO/flush),
//          divider handshake, stall/busy/done/hilo results
module mdu_ctrl (
  input logic       clk,
  input logic       rst,
  mdu_ctrl_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MSUB  = 4'd5;
  localparam logic [3:0] OP_MSUBU = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL      = 3'd1,
    ACC      = 3'd2,
    DIV_WAIT = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state_r;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] hilo_q;
  logic [63:0] prod_q;
  logic [63:0] res_q;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_plain_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_sub_acc(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  logic        accept_s;
  logic [63:0] ext_a_s;
  logic [63:0] ext_b_s;
  logic [63:0] product_s;
  logic [63:0] acc_s;

  // Accept is gated by rst so the stall request drops the moment reset is
  // asserted, even while EX keeps presenting its stalled instruction.
  assign accept_s = rst && (state_r == IDLE) && bus.valid_i && !bus.flush_i &&
                    (is_mul_op(bus.op_i) || is_div_op(bus.op_i));

  // Lower 64 bits of the product of the 64-bit extended operands are the
  // exact signed (or unsigned) 32x32 product.
  assign ext_a_s   = is_signed_mul(op_q) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign ext_b_s   = is_signed_mul(op_q) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign product_s = ext_a_s * ext_b_s;
  assign acc_s     = is_sub_acc(op_q) ? (hilo_q - prod_q) : (hilo_q + prod_q);

  // Sequencer state and operand/result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hilo_q  <= 64'd0;
      prod_q  <= 64'd0;
      res_q   <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_q   <= bus.op_i;
            a_q    <= bus.reg1_i;
            b_q    <= bus.reg2_i;
            hilo_q <= {bus.hi_i, bus.lo_i};
            if (is_mul_op(bus.op_i)) begin
              state_r <= MUL;
            end else if (bus.reg2_i != 32'd0) begin
              state_r <= DIV_WAIT;
            end else begin
              // Divide by zero leaves HI/LO unchanged.
              res_q   <= {bus.hi_i, bus.lo_i};
              state_r <= DONE;
            end
          end
        end
        MUL: begin
          if (bus.flush_i) begin
            state_r <= IDLE;
          end else begin
            prod_q <= product_s;
            if (is_plain_mul(op_q)) begin
              res_q   <= product_s;
              state_r <= DONE;
            end else begin
              state_r <= ACC;
            end
          end
        end
        ACC: begin
          if (bus.flush_i) begin
            state_r <= IDLE;
          end else begin
            res_q   <= acc_s;
            state_r <= DONE;
          end
        end
        DIV_WAIT: begin
          if (bus.flush_i) begin
            state_r <= IDLE;
          end else if (bus.div_ready_i) begin
            res_q   <= bus.div_result_i;
            state_r <= DONE;
          end
        end
        DONE: begin
          // The retiring instruction is still on valid_i here; never re-accept.
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.done_o        = (state_r == DONE) && !bus.flush_i;
  assign bus.hilo_o        = res_q;
  assign bus.busy_o        = (state_r != IDLE);
  assign bus.stallreq_o    = accept_s || (state_r == MUL) || (state_r == ACC) ||
                             (state_r == DIV_WAIT);
  assign bus.div_start_o   = (state_r == DIV_WAIT);
  assign bus.div_signed_o  = (state_r == DIV_WAIT) && (op_q == OP_DIV);
  assign bus.div_opdata1_o = (state_r == DIV_WAIT) ? a_q : 32'd0;
  assign bus.div_opdata2_o = (state_r == DIV_WAIT) ? b_q : 32'd0;
  assign bus.div_annul_o   = (state_r == DIV_WAIT) && bus.flush_i;

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer sitting beside the EX stage. It accepts one HI/LO-writing arithmetic operation at a time and computes MULT/MULTU/MADD/MADDU/MSUB/MSUBU with a registered two-stage multiply-accumulate. It delegates DIV/DIVU to the existing iterative divider through its start/ready handshake. It raises the EX stall request until a single-cycle `done_o` presents the final 64-bit {HI,LO} value for the pipeline to write back.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `valid_i`  in  1  EX holds an MDU operation this cycle
- `op_i`  in  4  0 NONE, 1 MULT, 2 MULTU, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU, 7 DIV, 8 DIVU; others treated as NONE
- `reg1_i`, `reg2_i`  in  32  rs, rt operands
- `hi_i`, `lo_i`  in  32  forwarded current HI/LO
- `flush_i`  in  1  exception/annul of the EX instruction
- `div_start_o`  out  1  divider start
- `div_signed_o`  out  1  signed divide
- `div_opdata1_o`, `div_opdata2_o`  out  32  dividend, divisor
- `div_annul_o`  out  1  abort divider
- `div_result_i`  in  64  {remainder, quotient}
- `div_ready_i`  in  1  divider result valid (1 cycle)
- `stallreq_o`  out  1  stall EX and earlier stages
- `busy_o`  out  1  state != IDLE
- `done_o`  out  1  result valid, 1 cycle
- `hilo_o`  out  64  {HI, LO} result

## Operation
- States: IDLE, MUL, ACC, DIV_WAIT, DONE.
- **Accept.** Accept happens in IDLE when `valid_i` and op != NONE and !`flush_i`. On accept, capture `op_q`, `a_q`=reg1_i, `b_q`=reg2_i and `hilo_q`={hi_i,lo_i}.
  - Multiply ops -> MUL.
  - DIV/DIVU with `reg2_i` != 0 -> DIV_WAIT.
  - DIV/DIVU with `reg2_i` == 0 -> DONE with `res_q`=`hilo_q`, so HI/LO are unchanged.
- **MUL.** `prod_q` = 64-bit product. Signed ops (MULT/MADD/MSUB) sign-extend both operands to 64 bits; unsigned ops zero-extend. MULT/MULTU -> DONE with `res_q`=product. MADD*/MSUB* -> ACC.
- **ACC.** `res_q` = `hilo_q` + `prod_q` (MADD*) or `hilo_q` - `prod_q` (MSUB*), modulo 2^64, no overflow flag. Then -> DONE.
- **DIV_WAIT.**
  - Drive `div_start_o`=1, `div_opdata1_o`=`a_q`, `div_opdata2_o`=`b_q`, `div_signed_o`=(op_q==DIV).
  - On `div_ready_i`: `res_q`=`div_result_i`, `div_start_o` falls the same cycle, next state DONE.
- **DONE.** `done_o`=1, `hilo_o`=`res_q`. Next state is IDLE unconditionally; the still-present `valid_i` of the retiring instruction is not re-accepted.
- **Flush.** `flush_i` in MUL/ACC/DIV_WAIT/DONE -> IDLE next cycle, and `done_o` is forced 0 that cycle. In DIV_WAIT, `div_annul_o`=1 combinationally while `flush_i`.
- **Divider outputs outside DIV_WAIT.** `div_*` outputs are 0.
- **Stall.** `stallreq_o` = (IDLE & accept) | state in {MUL, ACC, DIV_WAIT}. It is 0 in DONE.

## Timing
- Reset values: state IDLE; `stallreq_o`, `busy_o`, `done_o`, `div_start_o`, `div_signed_o`, `div_annul_o` = 0; `hilo_o`, `div_opdata*_o` = 0; all internal registers 0.
- Reset asserted mid-operation: immediate return to IDLE, outputs at reset values, divider left to the divider's own reset.
- Latencies, with accept in cycle T:
  - MULT/MULTU: `done_o` in T+2.
  - MADD/MSUB family: `done_o` in T+3.
  - DIV: `done_o` in R+1, where R is the `div_ready_i` cycle.
  - DIV by zero: `done_o` in T+1.
- `hilo_o` is valid only while `done_o`=1; it holds `res_q` otherwise.
- The accept decision is combinational on `valid_i`/`op_i`/`flush_i`. All other outputs are functions of registered state plus `flush_i`/`div_ready_i`.
- Back-to-back: a new op can be accepted the cycle after DONE, i.e. one idle cycle minimum between results.

## Test plan
- MULT reg1=0xFFFFFFFE (-2), reg2=3 -> stallreq 1 in T,T+1; done in T+2 with hilo_o=0xFFFFFFFF_FFFFFFFA. MULTU with the same operands -> hilo_o=0x00000002_FFFFFFFA.
- MADD hi/lo=0x00000000_00000010, reg1=4, reg2=5 -> done at T+3, hilo_o=0x00000000_00000024. MSUBU hi/lo=0, reg1=1, reg2=1 -> hilo_o=0xFFFFFFFF_FFFFFFFF.
- DIV reg1=-7, reg2=2 with a divider model whose ready arrives at T+34 returning {0xFFFFFFFF, 0xFFFFFFFD} -> div_start_o=1 and div_signed_o=1 over T+1..T+34, stall through T+34, done at T+35 with that value. DIVU reg2=0, hi/lo=0x1_2 -> done at T+1 with hilo_o=0x00000001_00000002, div_start_o never 1.
- flush_i asserted at T+5 during DIV_WAIT -> div_annul_o=1 that cycle, IDLE at T+6, no done_o, stallreq 0 at T+6. flush_i during ACC -> no done_o.
- rst driven low asynchronously mid-MUL -> all outputs 0 without waiting for a clock edge. After release, a MULT 3x3 completes normally with 9.
- Two consecutive MULTs held by a stall-respecting EX model -> exactly one done_o per instruction, with no re-acceptance in the DONE cycle.
